// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } hzState_e;

  localparam logic [1:0] ST_RUN      = 2'(RUN);
  localparam logic [1:0] ST_FLUSH    = 2'(FLUSH);
  localparam logic [1:0] ST_MEM_WAIT = 2'(MEM_WAIT);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Flush counter width, enough for FLUSH_CYCLES up to 7.
  localparam int FCW = 3;

endpackage

// File: rtl/hazard_sequencer_forward_unit.sv
// ALU operand forwarding selects; MEM result beats WB result, register 0 included.
module forward_unit
  import hazard_sequencer_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic [RW-1:0] Ra_E,
  input  logic [RW-1:0] Rb_E,
  input  logic [RW-1:0] Rc_M,
  input  logic [RW-1:0] Rc_W,
  input  logic          regWrite_M,
  input  logic          regWrite_W,
  output logic [1:0]    fwdA,
  output logic [1:0]    fwdB
);

  logic [1:0][RW-1:0] src;
  logic [1:0][1:0]    sel;

  assign src = {Rb_E, Ra_E};

  for (genvar i = 0; i < 2; i++) begin : gOp
    assign sel[i] = (regWrite_M && Rc_M == src[i]) ? FWD_MEM :
                    (regWrite_W && Rc_W == src[i]) ? FWD_WB  : FWD_RF;
  end

  assign fwdA = sel[0];
  assign fwdB = sel[1];

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/forward sequencer for the five-stage core.
// Define HAZARD_PERF_EN to add saturating stallCount/flushCount outputs.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int RW           = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] Ra_D,
  input  logic [RW-1:0] Rb_D,
  input  logic          useA_D,
  input  logic          useB_D,
  input  logic [RW-1:0] Ra_E,
  input  logic [RW-1:0] Rb_E,
  input  logic [RW-1:0] Rc_E,
  input  logic [RW-1:0] Rc_M,
  input  logic [RW-1:0] Rc_W,
  input  logic          regWrite_E,
  input  logic          regWrite_M,
  input  logic          regWrite_W,
  input  logic          memToReg_E,
  input  logic          branchTaken_E,
  input  logic          memBusy,
  output logic          enF,
  output logic          enD,
  output logic          enE,
  output logic          enM,
  output logic          enW,
  output logic          flushD,
  output logic          flushE,
  output logic [1:0]    fwdA,
  output logic [1:0]    fwdB,
  output logic [1:0]    state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CW-1:0] stallCount,
  output logic [CW-1:0] flushCount
`endif
);

  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

  logic [1:0]     stQ, stD, effSt;
  logic [FCW-1:0] cntQ, cntD;
  logic           loadUse, enFront, enBack;

  assign loadUse = regWrite_E & memToReg_E &
                   ((useA_D & (Rc_E == Ra_D)) | (useB_D & (Rc_E == Rb_D)));

  // When memory becomes ready the wait cycle already behaves as the state
  // it returns to, so a frozen branch/load in EX is resolved without a lost cycle.
  always_comb begin
    effSt = stQ;
    if (stQ == ST_MEM_WAIT && !memBusy)
      effSt = (cntQ != '0) ? ST_FLUSH : ST_RUN;
  end

  always_comb begin
    enFront = 1'b1;
    enBack  = 1'b1;
    flushD  = 1'b0;
    flushE  = 1'b0;
    stD     = effSt;
    cntD    = cntQ;
    if (memBusy) begin
      enFront = 1'b0;
      enBack  = 1'b0;
      stD     = ST_MEM_WAIT;
    end else if (effSt == ST_FLUSH) begin
      flushD = 1'b1;
      if (cntQ <= FCW'(1)) begin
        stD  = ST_RUN;
        cntD = '0;
      end else begin
        cntD = cntQ - FCW'(1);
      end
    end else if (branchTaken_E) begin
      flushD = 1'b1;
      flushE = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        stD  = ST_FLUSH;
        cntD = FLUSH_INIT;
      end
    end else if (loadUse) begin
      enFront = 1'b0;
      flushE  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stQ  <= ST_RUN;
      cntQ <= '0;
    end else begin
      stQ  <= stD;
      cntQ <= cntD;
    end
  end

  assign enF   = enFront;
  assign enD   = enFront;
  assign enE   = enBack;
  assign enM   = enBack;
  assign enW   = enBack;
  assign state = stQ;

`ifdef HAZARD_PERF_EN
  // Only an accepted taken branch raises both flushes in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (!enFront && stallCount != '1) stallCount <= stallCount + 1'b1;
      if (flushD && flushE && flushCount != '1) flushCount <= flushCount + 1'b1;
    end
  end
`endif

  forward_unit #(.RW(RW)) uFwd (
    .Ra_E       (Ra_E),
    .Rb_E       (Rb_E),
    .Rc_M       (Rc_M),
    .Rc_W       (Rc_W),
    .regWrite_M (regWrite_M),
    .regWrite_W (regWrite_W),
    .fwdA       (fwdA),
    .fwdB       (fwdB)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed table-driven bench for hazard_sequencer with FLUSH_CYCLES=3.
module tb_hazard_sequencer;

  logic       clk, rst;
  logic [3:0] Ra_D, Rb_D, Ra_E, Rb_E, Rc_E, Rc_M, Rc_W;
  logic       useA_D, useB_D, regWrite_E, regWrite_M, regWrite_W;
  logic       memToReg_E, branchTaken_E, memBusy;
  logic       enF, enD, enE, enM, enW, flushD, flushE;
  logic [1:0] fwdA, fwdB, state;
`ifdef HAZARD_PERF_EN
  logic [15:0] stallCount, flushCount;
`endif

  hazard_sequencer #(.RW(4), .FLUSH_CYCLES(3), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .Ra_D(Ra_D), .Rb_D(Rb_D), .useA_D(useA_D), .useB_D(useB_D),
    .Ra_E(Ra_E), .Rb_E(Rb_E), .Rc_E(Rc_E), .Rc_M(Rc_M), .Rc_W(Rc_W),
    .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memToReg_E(memToReg_E), .branchTaken_E(branchTaken_E), .memBusy(memBusy),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .flushD(flushD), .flushE(flushE), .fwdA(fwdA), .fwdB(fwdB), .state(state)
`ifdef HAZARD_PERF_EN
    , .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       mb, br, ld;
    logic [3:0] rcE, raD;
    logic       uA;
    logic [3:0] rcM, rcW;
    logic       wM, wW;
    logic [3:0] raE, rbE;
    logic [4:0] en;
    logic       fD, fE;
    logic [1:0] fA, fB, st;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string nm, logic mb, logic br, logic ld,
                              logic [3:0] rcE, logic [3:0] raD, logic uA,
                              logic [3:0] rcM, logic [3:0] rcW, logic wM, logic wW,
                              logic [3:0] raE, logic [3:0] rbE,
                              logic [4:0] en, logic fD, logic fE,
                              logic [1:0] fA, logic [1:0] fB, logic [1:0] st);
    vec_t v;
    v.nm = nm; v.mb = mb; v.br = br; v.ld = ld; v.rcE = rcE; v.raD = raD; v.uA = uA;
    v.rcM = rcM; v.rcW = rcW; v.wM = wM; v.wW = wW; v.raE = raE; v.rbE = rbE;
    v.en = en; v.fD = fD; v.fE = fE; v.fA = fA; v.fB = fB; v.st = st;
    return v;
  endfunction

  function automatic logic [12:0] actual();
    return {enF, enD, enE, enM, enW, flushD, flushE, fwdA, fwdB, state};
  endfunction

  task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got en=%b fD=%b fE=%b fA=%b fB=%b st=%b, want en=%b fD=%b fE=%b fA=%b fB=%b st=%b",
               nm, act[12:8], act[7], act[6], act[5:4], act[3:2], act[1:0],
               exp[12:8], exp[7], exp[6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic drive(vec_t v);
    memBusy = v.mb; branchTaken_E = v.br; memToReg_E = v.ld;
    Rc_E = v.rcE; Ra_D = v.raD; useA_D = v.uA;
    Rc_M = v.rcM; Rc_W = v.rcW; regWrite_M = v.wM; regWrite_W = v.wW;
    Ra_E = v.raE; Rb_E = v.rbE;
  endtask

  task automatic setIdle();
    drive(mk("idle", 0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1, 4'd2,
             5'h1F, 0, 0, 2'b00, 2'b00, 2'b00));
  endtask

  int expStall = 0;
  int expFlush = 0;

  initial begin
    rst = 1'b0; Rb_D = 4'd15; useB_D = 1'b0; regWrite_E = 1'b1;
    setIdle();

    // Reset while waiting on memory returns to RUN with no extra cycles.
    @(negedge clk); rst = 1'b1; memBusy = 1'b1;
    @(negedge clk); #1;
    chk("enter_memwait", actual(), {5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10});
    rst = 1'b0; memBusy = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; memBusy = 1'b0; #1;
    chk("reset_run", actual(), {5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00});
`ifdef HAZARD_PERF_EN
    total++;
    if (stallCount !== 16'd0 || flushCount !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d, want 0 0", stallCount, flushCount);
    end
`endif

    //              nm          mb br ld rcE   raD   uA rcM   rcW    wM wW raE    rbE    en        fD fE fA     fB     st
    vecs.push_back(mk("idle",     0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("loaduse",  0, 0, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00111, 0, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_fwd",   0, 0, 0, 4'd8, 4'd1, 1, 4'd3, 4'd10, 1, 1, 4'd3,  4'd2, 5'h1F,    0, 0, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk("lu_noUse", 0, 0, 1, 4'd3, 4'd3, 0, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_reg0",  0, 0, 1, 4'd0, 4'd0, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00111, 0, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("br",       0, 1, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("fl1_brIg", 0, 1, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("fl2",      0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("fl_done",  0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("br2",      0, 1, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("flmb1",    1, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("flmb2",    1, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("flmb3",    1, 1, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("flmb4",    1, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("flres1",   0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("flres2",   0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("flres_end",0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("all3",     1, 1, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("all3_mw",  1, 1, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("all3_rel", 0, 1, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 1, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("all3_fl1", 0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("all3_fl2", 0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'h1F,    1, 0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("mb_lu",    1, 0, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00000, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("mb_lu_rel",0, 0, 1, 4'd3, 4'd3, 1, 4'd9, 4'd10, 1, 1, 4'd1,  4'd2, 5'b00111, 0, 1, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("fwd_mem",  0, 0, 0, 4'd8, 4'd1, 1, 4'd5, 4'd5,  1, 1, 4'd1,  4'd5, 5'h1F,    0, 0, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk("fwd_wb",   0, 0, 0, 4'd8, 4'd1, 1, 4'd5, 4'd5,  0, 1, 4'd1,  4'd5, 5'h1F,    0, 0, 2'b00, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_none", 0, 0, 0, 4'd8, 4'd1, 1, 4'd5, 4'd5,  0, 0, 4'd1,  4'd5, 5'h1F,    0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_a_wb", 0, 0, 0, 4'd8, 4'd1, 1, 4'd9, 4'd10, 1, 1, 4'd10, 4'd2, 5'h1F,    0, 0, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_reg0", 0, 0, 0, 4'd8, 4'd1, 1, 4'd0, 4'd10, 1, 1, 4'd0,  4'd0, 5'h1F,    0, 0, 2'b01, 2'b01, 2'b00));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk(vecs[i].nm, actual(),
          {vecs[i].en, vecs[i].fD, vecs[i].fE, vecs[i].fA, vecs[i].fB, vecs[i].st});
      if (!vecs[i].en[4]) expStall++;
      if (vecs[i].fD && vecs[i].fE) expFlush++;
    end

`ifdef HAZARD_PERF_EN
    @(negedge clk); setIdle(); #1;
    total++;
    if (stallCount !== 16'(expStall) || flushCount !== 16'(expFlush)) begin
      bad++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d, want %0d %0d",
               stallCount, flushCount, expStall, expFlush);
    end
`endif

    // Reset in the middle of a flush sequence abandons it.
    @(negedge clk); setIdle(); branchTaken_E = 1'b1;
    @(negedge clk); branchTaken_E = 1'b0; #1;
    chk("pre_rst_flush", actual(), {5'b11111, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01});
    rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_mid_flush", actual(), {5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline control block for the 24-bit five-stage core: generates stage-register enables, flush requests and ALU operand forwarding selects so the execute stage and its EX_MEM buffer see correct operands. It sits beside the datapath, observes register numbers and control bits of the decode, execute, memory and writeback stages, and sequences load-use stalls, taken-branch flushes and multi-cycle memory waits through a small state machine.

## Interface

Parameters:
- RW, 4: register-number width.
- FLUSH_CYCLES, 1: cycles flushD stays asserted per taken branch (1..7).
- CW, 16: performance counter width (only with HAZARD_PERF_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- Ra_D, Rb_D  input  RW  decode-stage source registers.
- useA_D, useB_D  input  1  decode instruction reads Ra_D / Rb_D.
- Ra_E, Rb_E  input  RW  execute-stage source registers.
- Rc_E, Rc_M, Rc_W  input  RW  destination registers in EX, MEM, WB.
- regWrite_E, regWrite_M, regWrite_W  input  1  stage writes a register.
- memToReg_E  input  1  EX instruction is a load.
- branchTaken_E  input  1  branch resolved taken in EX.
- memBusy  input  1  data memory not ready this cycle.
- enF, enD, enE, enM, enW  output  1  stage-register enables (1 = advance).
- flushD, flushE  output  1  clear IF_ID / ID_EX contents (insert bubble).
- fwdA, fwdB  output  2  operand select: 00 register file, 01 MEM aluOut, 10 WB result.
- state  output  2  current FSM state (debug).
- stallCount, flushCount  output  CW  only with HAZARD_PERF_EN.

## Operation

- States: RUN=00, FLUSH=01, MEM_WAIT=10. Reset → RUN.
- Priority per cycle: memBusy > branchTaken_E > load-use.
- RUN:
  - memBusy=1: all en*=0, no flush; next MEM_WAIT.
  - else branchTaken_E=1: flushD=flushE=1, all en*=1; next FLUSH if FLUSH_CYCLES>1 (counter loaded FLUSH_CYCLES-1), else RUN.
  - else load-use (regWrite_E & memToReg_E & ((useA_D & Rc_E==Ra_D) | (useB_D & Rc_E==Rb_D))): enF=enD=0, flushE=1, enE=enM=enW=1; stays RUN (one-cycle bubble).
  - else all en*=1, no flush.
- FLUSH: flushD=1, flushE=0, all en*=1; counter decrements; →RUN when it reaches 1. memBusy overrides: →MEM_WAIT, remaining flush count retained and resumed after.
- MEM_WAIT: all en*=0, no flushes; →RUN (or FLUSH if count pending) on first cycle memBusy=0, outputs then per target state.
- A branchTaken_E during FLUSH or MEM_WAIT is ignored (EX contents are bubble/frozen).
- Forwarding (combinational, every state): fwdA=01 if regWrite_M & Rc_M==Ra_E; else 10 if regWrite_W & Rc_W==Ra_E; else 00. fwdB identical with Rb_E. MEM wins over WB. All register numbers compared, including 0.

## Timing

- While rst=0 at an edge: next state RUN, flush counter 0, counters 0. Outputs while state is RUN after reset follow RUN rules; no extra reset cycles.
- Reset mid-FLUSH or mid-MEM_WAIT: abandoned, RUN next cycle.
- Enables/flushes combinational from inputs and registered state; sampled by stage buffers at the next edge. Load-use penalty exactly 1 cycle; branch penalty 2 bubbles + (FLUSH_CYCLES-1).
- Forwarding selects zero-latency combinational.

## Configuration

- HAZARD_PERF_EN defined: stallCount increments each cycle enF=0 (load-use or MEM_WAIT); flushCount increments once per accepted taken branch; both saturate at all-ones, cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure

- Shared package: state enum (RUN, FLUSH, MEM_WAIT), fwd select constants FWD_RF=00, FWD_MEM=01, FWD_WB=10.
- One sub-module: forward_unit (pure comparator for fwdA/fwdB), instantiated once; FSM and counters in top.

## Test plan

- Reset: rst=0 two cycles in MEM_WAIT → state=00, all en=1, flushes 0, counters 0.
- Load-use: load Rc_E=3, Ra_D=3, useA_D=1 → one cycle enF=enD=0, flushE=1; next cycle Rc_M=3, Ra_E=3 → fwdA=01.
- Branch with FLUSH_CYCLES=3: branchTaken_E=1 → flushD=flushE=1, then flushD=1 two more cycles, state 01 → 00.
- memBusy 4 cycles during FLUSH → en*=0 four cycles, then remaining flushD cycles resume.
- Simultaneous memBusy=1, branchTaken_E=1, load-use → only MEM_WAIT; branch/load-use evaluated after memBusy drops.
- Forward priority: Rc_M=Rc_W=5, both write, Rb_E=5 → fwdB=01; regWrite_M=0 → fwdB=10.
